// File: rtl/clock_pkg.sv
// clock_pkg: shared definitions for the digital clock (core, display, time setter).
//   - Field widths and wrap limits for hour/minute/second.
//   - field_e: selected-field encoding used by the display blink logic.
//   - step_wrap(): +1/-1 on a time field with wrap at 0 and max.
package clock_pkg;

  localparam int unsigned HOUR_W = 5;
  localparam int unsigned MS_W   = 6;

  localparam logic [5:0] HOUR_MAX = 6'd23;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [5:0] SEC_MAX  = 6'd59;

  typedef enum logic [1:0] {
    FIELD_NONE = 2'd0,
    FIELD_HOUR = 2'd1,
    FIELD_MIN  = 2'd2,
    FIELD_SEC  = 2'd3
  } field_e;

  // Hours are passed zero-extended to 6 bits so one helper serves all fields.
  function automatic logic [5:0] step_wrap(input logic [5:0] v, input logic [5:0] max,
                                           input logic up);
    if (up) return (v >= max) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0) ? max : v - 6'd1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-FF synchroniser, stable-level debouncer and press-event generator
// for one active-low push-button.
//   clk, rst_n  clock, asynchronous active-low reset
//   i_key_n     raw button level, active-low
//   o_press     one-cycle pulse on each accepted press (and on auto-repeat ticks
//               when REPEAT_EN is set)
// Parameters: DEB_CYC stable cycles before a level is accepted; REPEAT_EN enables
// hold-to-repeat with HOLD_CYC initial delay and RATE_CYC repeat period.
module key_debounce #(
  parameter int unsigned DEB_CYC   = 2,
  parameter bit          REPEAT_EN = 1'b0,
  parameter int unsigned HOLD_CYC  = 500,
  parameter int unsigned RATE_CYC  = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key_n,
  output logic o_press
);

  localparam int unsigned DEB  = (DEB_CYC  == 0) ? 1 : DEB_CYC;
  localparam int unsigned HOLD = (HOLD_CYC == 0) ? 1 : HOLD_CYC;
  localparam int unsigned RATE = (RATE_CYC == 0) ? 1 : RATE_CYC;
  localparam int unsigned CW   = $clog2(DEB + 1);
  localparam int unsigned RW   = $clog2(((HOLD > RATE) ? HOLD : RATE) + 1);

  logic [1:0]    r_sync;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          r_press;
  logic [RW-1:0] r_rep_cnt;
  logic          r_rep_phase;
  logic          w_accept;
  logic          w_rep;

  // Accept on the DEB-th consecutive cycle the synced level differs from r_level.
  assign w_accept = (r_sync[1] != r_level) && (r_cnt == CW'(DEB - 1));
  assign w_rep    = REPEAT_EN && !r_level &&
                    (r_rep_cnt == (r_rep_phase ? RW'(RATE - 1) : RW'(HOLD - 1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync      <= 2'b11;
      r_level     <= 1'b1;
      r_cnt       <= '0;
      r_press     <= 1'b0;
      r_rep_cnt   <= '0;
      r_rep_phase <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_key_n};

      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end

      r_press <= (w_accept && !r_sync[1]) || w_rep;

      if (!REPEAT_EN || r_level) begin
        r_rep_cnt   <= '0;
        r_rep_phase <= 1'b0;
      end else if (w_rep) begin
        r_rep_cnt   <= '0;
        r_rep_phase <= 1'b1;
      end else begin
        r_rep_cnt <= r_rep_cnt + RW'(1);
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/clock_time_setter.sv
// clock_time_setter: push-button time-setting front end for the digital clock.
// Debounces three keys, runs the edit FSM (hour -> minute -> second -> commit) and
// writes the edited time back to the clock core with a one-cycle load strobe.
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_key_mode/inc/dec         raw buttons, active-low
//   i_cur_hour/min/sec         running time from the clock core
//   o_set_hour/min/sec         edited time
//   o_load                     one-cycle strobe, core loads o_set_*
//   o_setting                  high while editing (core holds its count)
//   o_field_sel                field being edited (clock_pkg::field_e)
//   o_blink                    square wave while editing, else 0
// Build option: define AUTO_REPEAT_EN to make held inc/dec keys auto-repeat
// (after 500 ms, at 10 Hz).
module clock_time_setter
  import clock_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 25_000_000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned TIMEOUT_S   = 10,
  parameter int unsigned BLINK_HZ    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_key_mode,
  input  logic              i_key_inc,
  input  logic              i_key_dec,
  input  logic [HOUR_W-1:0] i_cur_hour,
  input  logic [MS_W-1:0]   i_cur_min,
  input  logic [MS_W-1:0]   i_cur_sec,
  output logic [HOUR_W-1:0] o_set_hour,
  output logic [MS_W-1:0]   o_set_min,
  output logic [MS_W-1:0]   o_set_sec,
  output logic              o_load,
  output logic              o_setting,
  output logic [1:0]        o_field_sel,
  output logic              o_blink
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_HOUR   = 3'd1;
  localparam logic [2:0] ST_MIN    = 3'd2;
  localparam logic [2:0] ST_SEC    = 3'd3;
  localparam logic [2:0] ST_COMMIT = 3'd4;

  localparam int unsigned DEB_CYC = (CLK_FREQ / 1000) * DEBOUNCE_MS;
  localparam int unsigned TO_CYC  = (CLK_FREQ * TIMEOUT_S == 0) ? 1 : CLK_FREQ * TIMEOUT_S;
  localparam int unsigned HALF    = (CLK_FREQ / (2 * BLINK_HZ) == 0) ? 1
                                                                     : CLK_FREQ / (2 * BLINK_HZ);
  localparam int unsigned TW      = $clog2(TO_CYC + 1);
  localparam int unsigned BW      = $clog2(HALF + 1);

`ifdef AUTO_REPEAT_EN
  localparam bit REPEAT = 1'b1;
`else
  localparam bit REPEAT = 1'b0;
`endif

  logic [2:0]        r_state;
  logic [HOUR_W-1:0] r_hour;
  logic [MS_W-1:0]   r_min;
  logic [MS_W-1:0]   r_sec;
  logic [TW-1:0]     r_to_cnt;
  logic [BW-1:0]     r_blink_cnt;
  logic              r_blink;

  logic w_mode, w_inc, w_dec;
  logic w_up, w_dn, w_any, w_in_set, w_timeout;
  logic [5:0] w_hour_nxt, w_min_nxt, w_sec_nxt;

  key_debounce #(.DEB_CYC(DEB_CYC), .REPEAT_EN(1'b0), .HOLD_CYC(CLK_FREQ / 2),
                 .RATE_CYC(CLK_FREQ / 10))
    u_deb_mode (.clk(clk), .rst_n(rst_n), .i_key_n(i_key_mode), .o_press(w_mode));
  key_debounce #(.DEB_CYC(DEB_CYC), .REPEAT_EN(REPEAT), .HOLD_CYC(CLK_FREQ / 2),
                 .RATE_CYC(CLK_FREQ / 10))
    u_deb_inc (.clk(clk), .rst_n(rst_n), .i_key_n(i_key_inc), .o_press(w_inc));
  key_debounce #(.DEB_CYC(DEB_CYC), .REPEAT_EN(REPEAT), .HOLD_CYC(CLK_FREQ / 2),
                 .RATE_CYC(CLK_FREQ / 10))
    u_deb_dec (.clk(clk), .rst_n(rst_n), .i_key_n(i_key_dec), .o_press(w_dec));

  // Simultaneous inc+dec cancel; mode takes precedence over both.
  assign w_up      = w_inc && !w_dec && !w_mode;
  assign w_dn      = w_dec && !w_inc && !w_mode;
  assign w_any     = w_mode || w_inc || w_dec;
  assign w_in_set  = (r_state == ST_HOUR) || (r_state == ST_MIN) || (r_state == ST_SEC);
  assign w_timeout = (r_to_cnt == TW'(TO_CYC - 1)) && !w_any;

  always_comb begin
    w_hour_nxt = step_wrap({1'b0, r_hour}, HOUR_MAX, w_up);
    w_min_nxt  = step_wrap(r_min, MIN_MAX, w_up);
    w_sec_nxt  = step_wrap(r_sec, SEC_MAX, w_up);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_hour      <= '0;
      r_min       <= '0;
      r_sec       <= '0;
      r_to_cnt    <= '0;
      r_blink_cnt <= BW'(1);
      r_blink     <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: if (w_mode) begin
          r_state <= ST_HOUR;
          r_hour  <= i_cur_hour;
          r_min   <= i_cur_min;
          r_sec   <= i_cur_sec;
        end
        ST_HOUR: begin
          if (w_mode)                r_state <= ST_MIN;
          else if (w_timeout)        r_state <= ST_IDLE;
          else if (w_up || w_dn)     r_hour  <= w_hour_nxt[HOUR_W-1:0];
        end
        ST_MIN: begin
          if (w_mode)                r_state <= ST_SEC;
          else if (w_timeout)        r_state <= ST_IDLE;
          else if (w_up || w_dn)     r_min   <= w_min_nxt;
        end
        ST_SEC: begin
          if (w_mode)                r_state <= ST_COMMIT;
          else if (w_timeout)        r_state <= ST_IDLE;
          else if (w_up || w_dn)     r_sec   <= w_sec_nxt;
        end
        ST_COMMIT:                   r_state <= ST_IDLE;
        default:                     r_state <= ST_IDLE;
      endcase

      // Any accepted press restarts the inactivity timer.
      if (!w_in_set || w_any) r_to_cnt <= '0;
      else                    r_to_cnt <= r_to_cnt + TW'(1);

      if (r_state == ST_IDLE) begin
        r_blink_cnt <= BW'(1);
        r_blink     <= 1'b0;
      end else if (w_in_set) begin
        if (r_blink_cnt == BW'(HALF)) begin
          r_blink_cnt <= BW'(1);
          r_blink     <= !r_blink;
        end else begin
          r_blink_cnt <= r_blink_cnt + BW'(1);
        end
      end
    end
  end

  assign o_set_hour  = r_hour;
  assign o_set_min   = r_min;
  assign o_set_sec   = r_sec;
  assign o_load      = (r_state == ST_COMMIT);
  assign o_setting   = w_in_set;
  assign o_field_sel = w_in_set ? r_state[1:0] : FIELD_NONE;
  assign o_blink     = w_in_set && r_blink;

endmodule

// File: tb/tb_clock_time_setter.sv
// tb_clock_time_setter: directed self-checking bench for clock_time_setter, run with
// small timing parameters (1 kHz clock, 2 ms debounce, 1 s timeout, 100 Hz blink).
module tb_clock_time_setter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_mode = 1'b1, key_inc = 1'b1, key_dec = 1'b1;
  logic [4:0] cur_hour = '0;
  logic [5:0] cur_min = '0, cur_sec = '0;
  logic [4:0] set_hour;
  logic [5:0] set_min, set_sec;
  logic       load, setting, blink;
  logic [1:0] field_sel;

  int checks = 0;
  int errors = 0;
  int load_cnt = 0;

  always #5 clk = ~clk;

  clock_time_setter #(.CLK_FREQ(1000), .DEBOUNCE_MS(2), .TIMEOUT_S(1), .BLINK_HZ(100)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_key_mode(key_mode), .i_key_inc(key_inc), .i_key_dec(key_dec),
    .i_cur_hour(cur_hour), .i_cur_min(cur_min), .i_cur_sec(cur_sec),
    .o_set_hour(set_hour), .o_set_min(set_min), .o_set_sec(set_sec),
    .o_load(load), .o_setting(setting), .o_field_sel(field_sel), .o_blink(blink)
  );

  always @(posedge clk) if (load) load_cnt <= load_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Hold the selected keys low long enough to be accepted, then release and settle.
  task automatic press(input logic m, input logic i, input logic d);
    @(negedge clk);
    key_mode = ~m; key_inc = ~i; key_dec = ~d;
    repeat (6) @(negedge clk);
    key_mode = 1'b1; key_inc = 1'b1; key_dec = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic do_reset(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    cur_hour = h; cur_min = m; cur_sec = s;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lc;
    int toggles;
    logic prev;
    bit done;

    // Reset state
    do_reset(5'd5, 6'd3, 6'd21);
    check_eq("rst_setting", setting, 0);
    check_eq("rst_field", field_sel, 0);
    check_eq("rst_hms", {set_hour, set_min, set_sec}, 0);
    check_eq("rst_load", load_cnt, 0);
    check_eq("rst_blink", blink, 0);

    // 1: enter SET_HOUR with snapshot
    press(1, 0, 0);
    check_eq("t1_setting", setting, 1);
    check_eq("t1_field", field_sel, 1);
    check_eq("t1_hour", set_hour, 5);
    check_eq("t1_min", set_min, 3);
    check_eq("t1_sec", set_sec, 21);
    toggles = 0;
    prev = blink;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (blink != prev) toggles++;
      prev = blink;
    end
    check_eq("t1_blink_toggles", toggles, 4);

    // 2: wrap boundaries
    do_reset(5'd23, 6'd0, 6'd0);
    press(1, 0, 0);
    check_eq("t2_hour_snap", set_hour, 23);
    press(0, 1, 0);
    check_eq("t2_hour_wrap", set_hour, 0);
    press(1, 0, 0);
    check_eq("t2_field_min", field_sel, 2);
    press(0, 0, 1);
    check_eq("t2_min_wrap", set_min, 59);

    // 3: edit to 12:34:56 and commit
    do_reset(5'd11, 6'd35, 6'd55);
    press(1, 0, 0);
    press(0, 1, 0);
    press(1, 0, 0);
    press(0, 0, 1);
    press(1, 0, 0);
    press(0, 1, 0);
    check_eq("t3_field_sec", field_sel, 3);
    lc = load_cnt;
    press(1, 0, 0);
    check_eq("t3_load_once", load_cnt - lc, 1);
    check_eq("t3_hms", {set_hour, set_min, set_sec}, {5'd12, 6'd34, 6'd56});
    check_eq("t3_setting", setting, 0);
    check_eq("t3_field", field_sel, 0);
    press(0, 1, 0);
    check_eq("t3_idle_inc", set_hour, 12);

    // 4: bounce glitches rejected, solid press counted once
    cur_hour = 5'd7; cur_min = 6'd0; cur_sec = 6'd0;
    press(1, 0, 0);
    check_eq("t4_hour_snap", set_hour, 7);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk) key_inc = 1'b0;
      @(negedge clk) key_inc = 1'b1;
      repeat (3) @(negedge clk);
    end
    check_eq("t4_glitch", set_hour, 7);
    @(negedge clk) key_inc = 1'b0;
    repeat (4) @(negedge clk);
    key_inc = 1'b1;
    repeat (8) @(negedge clk);
    check_eq("t4_held", set_hour, 8);

    // 5: timeout in SET_MIN
    press(1, 0, 0);
    lc = load_cnt;
    repeat (950) @(negedge clk);
    check_eq("t5_not_early", setting, 1);
    done = 0;
    for (int k = 0; k < 150 && !done; k++) begin
      @(negedge clk);
      if (!setting) done = 1;
    end
    check_eq("t5_timed_out", done, 1);
    check_eq("t5_field", field_sel, 0);
    check_eq("t5_no_load", load_cnt - lc, 0);
    check_eq("t5_retained", set_hour, 8);

    // 6: inc+dec cancel, mode wins over inc, reset mid SET_SEC
    cur_hour = 5'd10; cur_min = 6'd20; cur_sec = 6'd30;
    press(1, 0, 0);
    press(0, 1, 1);
    check_eq("t6_incdec", set_hour, 10);
    press(1, 1, 0);
    check_eq("t6_mode_wins_field", field_sel, 2);
    check_eq("t6_mode_wins_hour", set_hour, 10);
    check_eq("t6_mode_wins_min", set_min, 20);
    press(1, 0, 0);
    press(0, 1, 0);
    check_eq("t6_sec_inc", set_sec, 31);
    lc = load_cnt;
    @(negedge clk) rst_n = 1'b0;
    #1;
    check_eq("t6_rst_setting", setting, 0);
    check_eq("t6_rst_field", field_sel, 0);
    check_eq("t6_rst_hms", {set_hour, set_min, set_sec}, 0);
    check_eq("t6_rst_blink", blink, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("t6_rst_no_load", load_cnt - lc, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
